rom_fetch_port: RTL

Synchronous, parametrised instruction ROM with a valid/ready request and response interface, the next generation of the core's combinational ROM. It sits between the fetch stage and block RAM. It registers every read so the array maps to BRAM with one-cycle latency. It tolerates stalls from the decode side and supports a redirect flush. It reports misaligned and out-of-range fetches instead of silently aliasing them.

---
 rtl/rom_fetch_port_if.sv | 25 ++
 rtl/rom_fetch_port.sv | 100 ++++++++++
 2 files changed

// File: rtl/rom_fetch_port_if.sv
// rtl/rom_fetch_port_if.sv - fetch request/response channel between the fetch stage and the instruction ROM
interface rom_fetch_port_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROM_WIDTH  = 32
);
  logic                  flush;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ROM_WIDTH-1:0]  rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic [1:0]            rsp_err;

  modport master (
    output flush, req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );

  modport slave (
    input  flush, req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
  );
endinterface

// File: rtl/rom_fetch_port.sv
// rtl/rom_fetch_port.sv - registered instruction ROM with one response slot, flush and fetch error reporting
module rom_fetch_port #(
  parameter string                 INIT_FILE  = "rom.mem",
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ROM_DEPTH  = 256,
  parameter int                    ROM_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic            clk,
  input  logic            rst,
  rom_fetch_port_if.slave bus
);
  localparam int SHIFT = $clog2(ROM_WIDTH / 8);
  localparam int IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'((64'd1 << SHIFT) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_WORDS = ADDR_WIDTH'(ROM_DEPTH);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [ROM_WIDTH-1:0] mem [0:ROM_DEPTH-1];

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned;
  logic                  below_base;
  logic                  beyond_end;
  logic                  in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic [1:0]            err_next;
  logic                  accept;
  logic                  take;

  // Offset wraps modulo 2^ADDR_WIDTH; below_base catches the wrapped case explicitly.
  always_comb begin
    offset     = bus.req_addr - BASE_ADDR;
    word_idx   = offset >> SHIFT;
    misaligned = |(bus.req_addr & ALIGN_MASK);
    below_base = bus.req_addr < BASE_ADDR;
    beyond_end = word_idx >= DEPTH_WORDS;
    in_range   = !below_base && !beyond_end;
    rd_idx     = in_range ? IDX_W'(word_idx) : '0;
    err_next   = {!in_range, misaligned};
  end

  assign accept = bus.req_valid && bus.req_ready;
  assign take   = bus.rsp_valid && bus.rsp_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (accept) state_next = FULL;
        FULL:    if (take && !accept) state_next = EMPTY;
        default: state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = (state == FULL);
    bus.req_ready = !bus.flush && ((state == EMPTY) || bus.rsp_ready);
  end

  logic [ROM_WIDTH-1:0]  data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            err_q;

  // Loaded only on accept so the read register holds its word through a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      addr_q <= '0;
      err_q  <= '0;
    end else if (accept) begin
      data_q <= (err_next == 2'b00) ? mem[rd_idx] : '0;
      addr_q <= bus.req_addr;
      err_q  <= err_next;
    end
  end

  assign bus.rsp_data = data_q;
  assign bus.rsp_addr = addr_q;
  assign bus.rsp_err  = err_q;
endmodule
